instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Fetch stage feeding the instruction queue. Holds the PC and requests 32-bit words from the memory controller.
//   Each returned word goes to the queue as a 1-cycle valid pulse with its PC.
//   A redirect from the ROB (mispredict or jump) squashes any in-flight fetch and restarts at the target PC.
// PARAMETERS
//   RESET_PC      32'h0  PC loaded on reset
//   ICACHE_IDX_W  8      icache index bits, 2^N lines of 1 word each (used only with ICACHE_EN)
// PORTS
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous reset, active low
//   rdy            in   1   global enable; 0 freezes every register
//   rob_jump_valid in   1   redirect request
//   rob_jump_pc    in   32  redirect target
//   iq_full        in   1   queue full (reports full with 2 slots of slack)
//   iq_inst_valid  out  1   instruction valid pulse to queue
//   iq_inst        out  32  instruction word
//   iq_pc          out  32  PC of iq_inst
//   mc_req         out  1   fetch request to memory controller, held until mc_valid
//   mc_addr        out  32  fetch address
//   mc_valid       in   1   fetch data valid, 1-cycle pulse
//   mc_inst        in   32  fetched word
// BEHAVIOUR
//   - Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, squash=0.
//     iq_inst_valid=0, iq_inst=0, iq_pc=0, mc_req=0, mc_addr=0.
//   - All outputs are registered. State updates only on edges where rdy=1; with rdy=0 every register holds.
//   - iq_inst_valid defaults to 0 on each rdy edge, so it is high for exactly one rdy cycle.
//   - FSM IDLE: if rob_jump_valid, pc<=rob_jump_pc and stay IDLE.
//     Else if !iq_full: mc_req<=1, mc_addr<=pc, go to WAIT.
//     Else: no action.
//   - FSM WAIT: mc_req stays high.
//     rob_jump_valid without mc_valid: pc<=rob_jump_pc, squash<=1.
//     mc_valid: mc_req<=0, go to IDLE.
//       squash=0 and no redirect this edge: iq_inst_valid<=1, iq_inst<=mc_inst, iq_pc<=pc, pc<=pc+4.
//       squash=1 or redirect this edge: word dropped, squash<=0; on redirect pc<=rob_jump_pc.
//   - Memory requests cannot be aborted; a squashed request completes and its data is discarded.
//   - Miss latency: req edge -> mc_valid edge -> valid pulse on the same edge.
//     Next request is issued one edge after return to IDLE.
//   - pc+4 wraps modulo 2^32; 32'hFFFFFFFC -> 32'h0. No alignment check.
//   - iq_full is sampled only when deciding whether to issue. A response in flight is always delivered;
//     the queue's 2-slot slack absorbs it.
//   - Redirect takes priority over every delivery in the same cycle.
// CONFIGURATION
//   ICACHE_EN defined: direct-mapped icache, one 32-bit word per line.
//     index=pc[ICACHE_IDX_W+1:2]; tag=pc[31:ICACHE_IDX_W+2]; valid bits cleared on reset.
//     IDLE hit with !iq_full and no redirect: deliver cached word and pc<=pc+4 on that edge, with no mc_req.
//     Hits therefore sustain 1 instruction per cycle.
//     On every mc_valid the line for mc_addr is filled, including squashed responses.
//     On a simultaneous fill and lookup of the same index, the lookup sees the old line.
//   ICACHE_EN undefined: no cache storage; every fetch uses the WAIT path above.
// TESTING
//   1. rst_n=0 mid-WAIT -> mc_req=0, iq_inst_valid=0, pc=RESET_PC; first req after release has mc_addr=0.
//   2. Memory returns 32'h00500093 five cycles after req for addr 0 -> one pulse, iq_inst=32'h00500093,
//      iq_pc=0; next mc_addr=4.
//   3. iq_full=1 for 10 cycles in IDLE -> mc_req stays 0; iq_full drops -> mc_req=1 on next edge.
//   4. Redirect to 32'h100 while addr 8 is outstanding -> no valid pulse for addr 8;
//      next mc_addr=32'h100; delivered iq_pc=32'h100.
//   5. Redirect coincident with mc_valid -> no pulse; next mc_addr=rob_jump_pc.
//      Holding rdy=0 during WAIT freezes all outputs.
//   6. pc=32'hFFFFFFFC fetch -> next mc_addr=0.
//      With ICACHE_EN, loop 0x100..0x10C twice -> second pass issues no mc_req and produces 4 pulses on 4 consecutive edges.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, requests words from the memory controller and
// forwards each returned word to the instruction queue. Optional icache: ICACHE_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        rob_jump_valid,
  input  logic [31:0] rob_jump_pc,
  input  logic        iq_full,
  output logic        iq_inst_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_valid,
  input  logic [31:0] mc_inst
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        squash;
  logic [31:0] pc_plus4;
  logic        hit;
  logic [31:0] cache_word;

  assign pc_plus4 = pc + 32'd4;

  if (ICACHE_IDX_W < 1 || ICACHE_IDX_W > 29) begin : g_bad_idx_w
    $error("instruction_fetch: ICACHE_IDX_W must be in 1..29");
  end

`ifdef ICACHE_EN
  localparam int unsigned LINES = 1 << ICACHE_IDX_W;
  localparam int unsigned TAG_W = 30 - ICACHE_IDX_W;

  logic [LINES-1:0]        line_valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];
  logic [ICACHE_IDX_W-1:0] lookup_idx;
  logic [ICACHE_IDX_W-1:0] fill_idx;
  logic                    fill;

  assign lookup_idx = pc[ICACHE_IDX_W+1:2];
  assign fill_idx   = mc_addr[ICACHE_IDX_W+1:2];
  assign fill       = rdy && (state == S_WAIT) && mc_valid;
  assign hit        = line_valid[lookup_idx] &&
                      (tag_mem[lookup_idx] == pc[31:ICACHE_IDX_W+2]);
  assign cache_word = data_mem[lookup_idx];

  // Squashed responses still fill; lookups read pre-edge contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_valid <= '0;
    end else if (fill) begin
      line_valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[fill_idx]  <= mc_addr[31:ICACHE_IDX_W+2];
      data_mem[fill_idx] <= mc_inst;
    end
  end
`else
  assign hit        = 1'b0;
  assign cache_word = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      squash        <= 1'b0;
      iq_inst_valid <= 1'b0;
      iq_inst       <= '0;
      iq_pc         <= '0;
      mc_req        <= 1'b0;
      mc_addr       <= '0;
    end else if (rdy) begin
      iq_inst_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rob_jump_valid) begin
            pc <= rob_jump_pc;
          end else if (!iq_full) begin
            if (hit) begin
              iq_inst_valid <= 1'b1;
              iq_inst       <= cache_word;
              iq_pc         <= pc;
              pc            <= pc_plus4;
            end else begin
              mc_req  <= 1'b1;
              mc_addr <= pc;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mc_valid) begin
            mc_req <= 1'b0;
            state  <= S_IDLE;
            if (!squash && !rob_jump_valid) begin
              iq_inst_valid <= 1'b1;
              iq_inst       <= mc_inst;
              iq_pc         <= pc;
              pc            <= pc_plus4;
            end else begin
              squash <= 1'b0;
              if (rob_jump_valid) pc <= rob_jump_pc;
            end
          end else if (rob_jump_valid) begin
            pc     <= rob_jump_pc;
            squash <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (default build; cache scenario when ICACHE_EN is defined).
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        rob_jump_valid;
  logic [31:0] rob_jump_pc;
  logic        iq_full;
  logic        iq_inst_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid;
  logic [31:0] mc_inst;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch #(.RESET_PC(32'h0), .ICACHE_IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .rob_jump_valid(rob_jump_valid), .rob_jump_pc(rob_jump_pc),
    .iq_full(iq_full), .iq_inst_valid(iq_inst_valid), .iq_inst(iq_inst),
    .iq_pc(iq_pc), .mc_req(mc_req), .mc_addr(mc_addr),
    .mc_valid(mc_valid), .mc_inst(mc_inst)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [31:0] d);
    mc_valid = 1'b1;
    mc_inst  = d;
    step();
    mc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; rob_jump_valid = 1'b0; rob_jump_pc = '0;
    iq_full = 1'b0; mc_valid = 1'b0; mc_inst = '0;
    #12;
    n_checks++;
    if ({iq_inst_valid, iq_inst, iq_pc, mc_req, mc_addr} !== 98'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b inst=%h pc=%h req=%b addr=%h, want all zero",
                         iq_inst_valid, iq_inst, iq_pc, mc_req, mc_addr);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h0) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h, want 1 00000000", mc_req, mc_addr);
    end
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mc_req !== 1'b0 || iq_inst_valid !== 1'b0 || mc_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_wait: got req=%b v=%b addr=%h, want 0 0 00000000",
                         mc_req, iq_inst_valid, mc_addr);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h0) begin
      n_fail++; $display("FAIL req_after_reset: got req=%b addr=%h, want 1 00000000", mc_req, mc_addr);
    end
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (mc_req !== 1'b1 || iq_inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL req_held[%0d]: got req=%b v=%b, want 1 0", i, mc_req, iq_inst_valid);
      end
    end
    respond(32'h00500093);
    n_checks++;
    if (iq_inst_valid !== 1'b1 || iq_inst !== 32'h00500093 || iq_pc !== 32'h0 || mc_req !== 1'b0) begin
      n_fail++; $display("FAIL deliver0: got v=%b inst=%h pc=%h req=%b, want 1 00500093 00000000 0",
                         iq_inst_valid, iq_inst, iq_pc, mc_req);
    end
    step();
    n_checks++;
    if (iq_inst_valid !== 1'b0 || mc_req !== 1'b1 || mc_addr !== 32'h4) begin
      n_fail++; $display("FAIL next_req4: got v=%b req=%b addr=%h, want 0 1 00000004",
                         iq_inst_valid, mc_req, mc_addr);
    end
  endtask

  task automatic test_full();
    iq_full = 1'b1;
    respond(32'h11111111);
    n_checks++;
    if (iq_inst_valid !== 1'b1 || iq_pc !== 32'h4 || iq_inst !== 32'h11111111) begin
      n_fail++; $display("FAIL deliver_while_full: got v=%b pc=%h inst=%h, want 1 00000004 11111111",
                         iq_inst_valid, iq_pc, iq_inst);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (mc_req !== 1'b0 || iq_inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL full_stall[%0d]: got req=%b v=%b, want 0 0", i, mc_req, iq_inst_valid);
      end
    end
    iq_full = 1'b0;
    step();
    n_checks++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h8) begin
      n_fail++; $display("FAIL req_after_full: got req=%b addr=%h, want 1 00000008", mc_req, mc_addr);
    end
  endtask

  task automatic test_redirect();
    rob_jump_valid = 1'b1; rob_jump_pc = 32'h100;
    step();
    rob_jump_valid = 1'b0;
    n_checks++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h8) begin
      n_fail++; $display("FAIL redirect_req_held: got req=%b addr=%h, want 1 00000008", mc_req, mc_addr);
    end
    step();
    respond(32'h22222222);
    n_checks++;
    if (iq_inst_valid !== 1'b0 || mc_req !== 1'b0) begin
      n_fail++; $display("FAIL squashed_word: got v=%b req=%b, want 0 0", iq_inst_valid, mc_req);
    end
    step();
    n_checks++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h100) begin
      n_fail++; $display("FAIL req_target: got req=%b addr=%h, want 1 00000100", mc_req, mc_addr);
    end
    respond(32'h33333333);
    n_checks++;
    if (iq_inst_valid !== 1'b1 || iq_pc !== 32'h100 || iq_inst !== 32'h33333333) begin
      n_fail++; $display("FAIL deliver_target: got v=%b pc=%h inst=%h, want 1 00000100 33333333",
                         iq_inst_valid, iq_pc, iq_inst);
    end
    step();
    n_checks++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h104) begin
      n_fail++; $display("FAIL req_104: got req=%b addr=%h, want 1 00000104", mc_req, mc_addr);
    end
  endtask

  task automatic test_redirect_coincident();
    rob_jump_valid = 1'b1; rob_jump_pc = 32'h200;
    respond(32'h44444444);
    rob_jump_valid = 1'b0;
    n_checks++;
    if (iq_inst_valid !== 1'b0 || mc_req !== 1'b0) begin
      n_fail++; $display("FAIL coincident_drop: got v=%b req=%b, want 0 0", iq_inst_valid, mc_req);
    end
    step();
    n_checks++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h200) begin
      n_fail++; $display("FAIL coincident_target: got req=%b addr=%h, want 1 00000200", mc_req, mc_addr);
    end
    rdy = 1'b0; mc_valid = 1'b1; mc_inst = 32'hDEADBEEF;
    rob_jump_valid = 1'b1; rob_jump_pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h200 || iq_inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL rdy_freeze_wait[%0d]: got req=%b addr=%h v=%b, want 1 00000200 0",
                           i, mc_req, mc_addr, iq_inst_valid);
      end
    end
    mc_valid = 1'b0; rob_jump_valid = 1'b0; rdy = 1'b1;
    respond(32'h55555555);
    n_checks++;
    if (iq_inst_valid !== 1'b1 || iq_pc !== 32'h200 || iq_inst !== 32'h55555555) begin
      n_fail++; $display("FAIL deliver_200: got v=%b pc=%h inst=%h, want 1 00000200 55555555",
                         iq_inst_valid, iq_pc, iq_inst);
    end
    rdy = 1'b0;
    repeat (2) step();
    n_checks++;
    if (iq_inst_valid !== 1'b1 || mc_req !== 1'b0) begin
      n_fail++; $display("FAIL rdy_freeze_pulse: got v=%b req=%b, want 1 0", iq_inst_valid, mc_req);
    end
    rdy = 1'b1;
    step();
    n_checks++;
    if (iq_inst_valid !== 1'b0 || mc_req !== 1'b1 || mc_addr !== 32'h204) begin
      n_fail++; $display("FAIL after_unfreeze: got v=%b req=%b addr=%h, want 0 1 00000204",
                         iq_inst_valid, mc_req, mc_addr);
    end
  endtask

  task automatic test_wrap();
    respond(32'h66666666);
    rob_jump_valid = 1'b1; rob_jump_pc = 32'hFFFFFFFC;
    step();
    rob_jump_valid = 1'b0;
    n_checks++;
    if (mc_req !== 1'b0 || iq_inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_redirect: got req=%b v=%b, want 0 0", mc_req, iq_inst_valid);
    end
    step();
    n_checks++;
    if (mc_req !== 1'b1 || mc_addr !== 32'hFFFFFFFC) begin
      n_fail++; $display("FAIL req_top: got req=%b addr=%h, want 1 fffffffc", mc_req, mc_addr);
    end
    respond(32'h77777777);
    n_checks++;
    if (iq_inst_valid !== 1'b1 || iq_pc !== 32'hFFFFFFFC) begin
      n_fail++; $display("FAIL deliver_top: got v=%b pc=%h, want 1 fffffffc", iq_inst_valid, iq_pc);
    end
    step();
`ifdef ICACHE_EN
    n_checks++;
    if (mc_req !== 1'b0 || iq_inst_valid !== 1'b1 || iq_pc !== 32'h0 || iq_inst !== 32'h00500093) begin
      n_fail++; $display("FAIL wrap_hit0: got req=%b v=%b pc=%h inst=%h, want 0 1 00000000 00500093",
                         mc_req, iq_inst_valid, iq_pc, iq_inst);
    end
`else
    n_checks++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr: got req=%b addr=%h, want 1 00000000", mc_req, mc_addr);
    end
`endif
  endtask

`ifdef ICACHE_EN
  task automatic test_icache();
    logic [31:0] words [4];
    words[0] = 32'hA0000000; words[1] = 32'hA1111111;
    words[2] = 32'hA2222222; words[3] = 32'hA3333333;
    rst_n = 1'b0;
    rob_jump_valid = 1'b1; rob_jump_pc = 32'h100;
    #1;
    rst_n = 1'b1;
    step();
    rob_jump_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h100 + 32'(4 * i)) begin
        n_fail++; $display("FAIL miss_req[%0d]: got req=%b addr=%h, want 1 %h",
                           i, mc_req, mc_addr, 32'h100 + 32'(4 * i));
      end
      respond(words[i]);
    end
    rob_jump_valid = 1'b1; rob_jump_pc = 32'h100;
    step();
    rob_jump_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (mc_req !== 1'b0 || iq_inst_valid !== 1'b1 || iq_pc !== 32'h100 + 32'(4 * i) ||
          iq_inst !== words[i]) begin
        n_fail++; $display("FAIL hit[%0d]: got req=%b v=%b pc=%h inst=%h, want 0 1 %h %h",
                           i, mc_req, iq_inst_valid, iq_pc, iq_inst, 32'h100 + 32'(4 * i), words[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_full();
    test_redirect();
    test_redirect_coincident();
    test_wrap();
`ifdef ICACHE_EN
    test_icache();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
